// File: rtl/lcd_button_poller.sv
// Avalon-MM read master that polls a single-bit button PIO, debounces bit 0 and
// produces a clean level, press/release pulses and a saturating press count.
module lcd_button_poller #(
  parameter int unsigned POLL_CYCLES      = 50000,
  parameter int unsigned READ_LATENCY     = 1,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter bit          ACTIVE_LOW       = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        button_pressed,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic [15:0] press_count
);

  localparam int unsigned TIMER_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int unsigned COUNT_W = 16;

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_CYCLES - 1);
  localparam logic [LAT_W-1:0]   LAT_RELOAD   = LAT_W'(READ_LATENCY - 1);
  localparam logic [DEB_W-1:0]   DEB_TARGET   = DEB_W'(DEBOUNCE_SAMPLES);
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_EVAL = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [DEB_W-1:0]    deb_inc;
  logic                pending_q, pending_d;
  logic                raw_q, raw_d;
  logic                read_d;
  logic                pressed_d;
  logic                press_pulse_d;
  logic                release_pulse_d;
  logic [COUNT_W-1:0]  count_d;
  logic                raw;
  logic                timer_run;
  logic                timer_expire;
  logic                unused_readdata;

  assign avm_address     = 2'd0;
  assign raw             = avm_readdata[0] ^ ACTIVE_LOW;
  assign unused_readdata = ^avm_readdata[31:1];
  assign deb_inc         = deb_q + DEB_W'(1);

  // Timer only freezes when idle and disabled, so the poll period stays exact.
  assign timer_run    = enable || (state_q != S_IDLE);
  assign timer_expire = timer_run && (timer_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable && ((timer_q == '0) || pending_q)) state_d = S_READ;
      S_READ:  if (!avm_waitrequest) state_d = S_WAIT;
      S_WAIT:  if (lat_q == '0) state_d = S_EVAL;
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d         = timer_q;
    lat_d           = lat_q;
    deb_d           = deb_q;
    pending_d       = pending_q;
    raw_d           = raw_q;
    pressed_d       = button_pressed;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    count_d         = press_count;
    read_d          = (state_d == S_READ);

    if (timer_run) timer_d = (timer_q == '0) ? TIMER_RELOAD : timer_q - TIMER_W'(1);

    // At most one missed poll is remembered; idle either consumes or drops it.
    if (state_q == S_IDLE)             pending_d = 1'b0;
    else if (timer_expire && enable)   pending_d = 1'b1;

    case (state_q)
      S_READ: begin
        if (!avm_waitrequest) lat_d = LAT_RELOAD;
      end
      S_WAIT: begin
        if (lat_q == '0) raw_d = raw;
        else             lat_d = lat_q - LAT_W'(1);
      end
      S_EVAL: begin
        if (raw_q == button_pressed) begin
          deb_d = '0;
        end else if (deb_inc == DEB_TARGET) begin
          deb_d           = '0;
          pressed_d       = raw_q;
          press_pulse_d   = raw_q;
          release_pulse_d = !raw_q;
          if (raw_q && (press_count != COUNT_MAX)) count_d = press_count + COUNT_W'(1);
        end else begin
          deb_d = deb_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q        <= TIMER_RELOAD;
      lat_q          <= '0;
      deb_q          <= '0;
      pending_q      <= 1'b0;
      raw_q          <= 1'b0;
      avm_read       <= 1'b0;
      button_pressed <= 1'b0;
      press_pulse    <= 1'b0;
      release_pulse  <= 1'b0;
      press_count    <= '0;
    end else begin
      timer_q        <= timer_d;
      lat_q          <= lat_d;
      deb_q          <= deb_d;
      pending_q      <= pending_d;
      raw_q          <= raw_d;
      avm_read       <= read_d;
      button_pressed <= pressed_d;
      press_pulse    <= press_pulse_d;
      release_pulse  <= release_pulse_d;
      press_count    <= count_d;
    end
  end

endmodule

// File: tb/tb_lcd_button_poller.sv
// Self-checking bench for lcd_button_poller: a registered PIO model, a table of
// per-poll expectations fed through a scoreboard, plus stall and reset sequences.
module tb_lcd_button_poller;

  localparam int unsigned POLL = 8;

  typedef struct {
    logic        in_val;
    logic        pressed;
    logic        pp;
    logic        rp;
    logic [15:0] count;
  } vec_t;

  typedef struct {
    logic        pressed;
    logic        pp;
    logic        rp;
    logic [15:0] count;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        waitreq;
  logic [31:0] pio_readdata;
  logic        button_pressed;
  logic        press_pulse;
  logic        release_pulse;
  logic [15:0] press_count;
  logic        in_port;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   exp_read_cyc;
  exp_t sb[$];

  lcd_button_poller #(
    .POLL_CYCLES     (POLL),
    .READ_LATENCY    (1),
    .DEBOUNCE_SAMPLES(3),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(waitreq),
    .avm_readdata   (pio_readdata),
    .button_pressed (button_pressed),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .press_count    (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // PIO slave: registered readdata, junk in every bit it should not matter in.
  always @(posedge clk) begin
    if (avm_read && !waitreq) pio_readdata <= {31'($urandom), in_port};
    else                      pio_readdata <= $urandom;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic i, input logic p, input logic pp,
                              input logic rp, input logic [15:0] c);
    vec_t v;
    v.in_val = i; v.pressed = p; v.pp = pp; v.rp = rp; v.count = c;
    return v;
  endfunction

  task automatic wait_read(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!avm_read && n < 40) begin
      step();
      n++;
    end
    if (!avm_read) begin
      checks++;
      errors++;
      ok = 1'b0;
      $display("FAIL read_timeout: avm_read 0 after 40 cycles, expected 1");
    end
  endtask

  // One poll: check issue timing, then check outputs two edges after acceptance.
  task automatic do_poll(input vec_t v);
    bit   ok;
    exp_t e;
    in_port = v.in_val;
    wait_read(ok);
    if (!ok) return;
    check("read_cycle", cyc, exp_read_cyc);
    check("read_address", avm_address, 0);
    exp_read_cyc += POLL;
    e.pressed = v.pressed; e.pp = v.pp; e.rp = v.rp; e.count = v.count;
    sb.push_back(e);
    step();
    check("read_width", avm_read, 0);
    step();
    step();
    e = sb.pop_front();
    check("button_pressed", button_pressed, e.pressed);
    check("press_pulse", press_pulse, e.pp);
    check("release_pulse", release_pulse, e.rp);
    check("press_count", press_count, e.count);
    step();
    check("press_pulse_width", press_pulse, 0);
    check("release_pulse_width", release_pulse, 0);
  endtask

  initial begin
    vec_t    vecs[$];
    bit      ok;
    bit      hold_ok;
    bit      prev;
    int      r;
    int      rises;
    int      first;

    // idle, 3-sample press, release, bounce then press, release
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'd2));

    reset_n = 1'b0;
    enable  = 1'b1;
    in_port = 1'b1;
    waitreq = 1'b0;
    step();
    step();
    check("reset_avm_read", avm_read, 0);
    check("reset_avm_address", avm_address, 0);
    check("reset_button_pressed", button_pressed, 0);
    check("reset_press_pulse", press_pulse, 0);
    check("reset_release_pulse", release_pulse, 0);
    check("reset_press_count", press_count, 0);

    reset_n      = 1'b1;
    exp_read_cyc = POLL;
    for (int i = 0; i < vecs.size(); i++) do_poll(vecs[i]);

    // Long stall: two expiries collapse into one immediate follow-up read.
    waitreq = 1'b1;
    wait_read(ok);
    if (ok) begin
      r = cyc;
      check("stall_read_cycle", r, exp_read_cyc);
      hold_ok = 1'b1;
      for (int i = 0; i < 21; i++) begin
        if (!avm_read) hold_ok = 1'b0;
        step();
      end
      check("stall_read_held", hold_ok, 1);
      waitreq = 1'b0;
      prev  = 1'b1;
      rises = 0;
      first = -1;
      for (int i = 0; i < 10; i++) begin
        step();
        if (avm_read && !prev) begin
          rises++;
          if (first < 0) first = cyc;
        end
        prev = avm_read;
      end
      check("stall_followup_reads", rises, 1);
      check("stall_followup_cycle", first, r + 25);
      exp_read_cyc = r + 32;
    end
    do_poll(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd2));
    do_poll(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
    do_poll(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd2));
    do_poll(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd3));

    // Reset in the middle of a read.
    wait_read(ok);
    reset_n = 1'b0;
    #1;
    check("midread_avm_read", avm_read, 0);
    check("midread_button_pressed", button_pressed, 0);
    check("midread_press_pulse", press_pulse, 0);
    check("midread_release_pulse", release_pulse, 0);
    check("midread_press_count", press_count, 0);

    // Saturation: preload the counter, then one more press.
    force dut.press_count = 16'hFFFF;
    step();
    step();
    reset_n      = 1'b1;
    exp_read_cyc = POLL;
    step();
    release dut.press_count;
    #1;
    check("sat_preload", press_count, 16'hFFFF);
    do_poll(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF));
    do_poll(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF));
    do_poll(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
